// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-granular round-robin arbiter feeding one registered valid/ready stream.
module stream_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 64,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [NUM_REQ*WIDTH-1:0] i_in_data,
    input  logic [NUM_REQ-1:0]       i_in_valid,
    input  logic [NUM_REQ-1:0]       i_in_last,
    output logic [NUM_REQ-1:0]       o_in_ready,
    output logic [WIDTH-1:0]         o_out_data,
    output logic                     o_out_valid,
    output logic                     o_out_last,
    output logic [IDX_W-1:0]         o_out_src,
    input  logic                     i_out_ready,
    output logic                     o_busy,
    output logic                     o_err_truncate
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_grant, r_last_grant, w_sel;
    logic [15:0]      r_beat_cnt;
    logic             w_ld, w_xfer, w_last, w_any;

    assign w_any      = |i_in_valid;
    assign w_ld       = ~o_out_valid | i_out_ready;
    assign w_xfer     = (r_state == GRANT) && i_in_valid[r_grant] && w_ld;
    assign w_last     = i_in_last[r_grant] || (r_beat_cnt == 16'(MAX_BEATS - 1));
    assign o_in_ready = (r_state == GRANT && w_ld) ? (NUM_REQ'(1) << r_grant) : '0;
    assign o_busy     = (r_state == GRANT);

    // Scan downward so the candidate closest after last_grant is written last and wins.
    always_comb begin
        int j;
        j     = 0;
        w_sel = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = (int'(r_last_grant) + i) % NUM_REQ;
            if (i_in_valid[j[IDX_W-1:0]]) w_sel = j[IDX_W-1:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE && w_any) w_state_next = GRANT;
        if (w_xfer && w_last) w_state_next = IDLE;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= IDLE;
            r_grant        <= '0;
            r_last_grant   <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt     <= '0;
            o_out_data     <= '0;
            o_out_valid    <= 1'b0;
            o_out_last     <= 1'b0;
            o_out_src      <= '0;
            o_err_truncate <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            o_err_truncate <= w_xfer && w_last && !i_in_last[r_grant];
            if (w_xfer) begin
                o_out_data  <= i_in_data[r_grant*WIDTH +: WIDTH];
                o_out_last  <= w_last;
                o_out_src   <= r_grant;
                o_out_valid <= 1'b1;
                r_beat_cnt  <= r_beat_cnt + 16'd1;
            end else if (w_ld) begin
                o_out_valid <= 1'b0;
            end
            if (r_state == IDLE && w_any) begin
                r_grant    <= w_sel;
                r_beat_cnt <= '0;
            end
            if (w_xfer && w_last) r_last_grant <= r_grant;
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed and random traffic checked against a packet-level round-robin model.
module tb_stream_rr_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0, rst_n = 1'b0, sel = 1'b0, dn_rdy = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   vld = '0, lst = '0, hold = '0, stuck = '0;
    logic [N-1:0]   vld_a, vld_b, a_ready, b_ready, w_ready;
    logic [W-1:0]   a_data, b_data, w_data;
    logic [1:0]     a_src, b_src, w_src;
    logic           a_valid, b_valid, a_last, b_last, a_busy, b_busy, a_err, b_err;
    logic           w_valid, w_last, w_busy, w_err;

    assign vld_a   = sel ? '0 : vld;
    assign vld_b   = sel ? vld : '0;
    assign w_ready = sel ? b_ready : a_ready;
    assign w_data  = sel ? b_data : a_data;
    assign w_src   = sel ? b_src : a_src;
    assign w_valid = sel ? b_valid : a_valid;
    assign w_last  = sel ? b_last : a_last;
    assign w_busy  = sel ? b_busy : a_busy;
    assign w_err   = sel ? b_err : a_err;

    stream_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BEATS(64)) u_dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_in_data(in_data), .i_in_valid(vld_a),
        .i_in_last(lst), .o_in_ready(a_ready), .o_out_data(a_data), .o_out_valid(a_valid),
        .o_out_last(a_last), .o_out_src(a_src), .i_out_ready(dn_rdy), .o_busy(a_busy),
        .o_err_truncate(a_err));

    stream_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BEATS(4)) u_trunc (
        .i_clock(clk), .i_reset_n(rst_n), .i_in_data(in_data), .i_in_valid(vld_b),
        .i_in_last(lst), .o_in_ready(b_ready), .o_out_data(b_data), .o_out_valid(b_valid),
        .o_out_last(b_last), .o_out_src(b_src), .i_out_ready(dn_rdy), .o_busy(b_busy),
        .o_err_truncate(b_err));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0, owner = -1, cnt = 0, trunc_pulses = 0, bp_mode = 0;
    int lo[2];
    bit trunc_exp;
    logic [16:0] rq[N][$];
    logic [18:0] exp_q[$];
    int lg_src[$], lg_data[$], lg_last[$], lg_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " a_valid"}, a_valid, 0);
        chk({tag, " a_ready"}, a_ready, 0);
        chk({tag, " a_busy"}, a_busy, 0);
        chk({tag, " a_data"}, a_data, 0);
        chk({tag, " a_last"}, a_last, 0);
        chk({tag, " a_src"}, a_src, 0);
        chk({tag, " a_err"}, a_err, 0);
        chk({tag, " b_valid"}, b_valid, 0);
        chk({tag, " b_ready"}, b_ready, 0);
    endtask

    task automatic model_reset();
        owner = -1; cnt = 0; lo[0] = N - 1; lo[1] = N - 1; trunc_exp = 0; stuck = '0;
        exp_q.delete();
    endtask

    function automatic int rr();
        for (int i = 1; i <= N; i++) begin
            int j = (lo[sel] + i) % N;
            if (vld[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit all_idle();
        int s = 0;
        for (int k = 0; k < N; k++) s += rq[k].size();
        return owner < 0 && exp_q.size() == 0 && s == 0;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() > 0 && (!hold[k] || stuck[k])) begin
                vld[k] = 1'b1; lst[k] = rq[k][0][16]; in_data[k*W +: W] = rq[k][0][15:0];
            end else begin
                vld[k] = 1'b0; lst[k] = 1'b0; in_data[k*W +: W] = '0;
            end
        end
        dn_rdy = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? (cyc % 5 < 2) : ($urandom % 3 != 0);
    endtask

    task automatic monitor(output logic [N-1:0] hs);
        logic ld;
        logic [18:0] e;
        int g;
        bit lb;
        ld = !w_valid || dn_rdy;
        chk("in_ready", w_ready, (owner >= 0 && ld) ? (1 << owner) : 0);
        chk("busy", w_busy, owner >= 0);
        chk("out_valid", w_valid, exp_q.size() != 0);
        chk("err_truncate", w_err, trunc_exp);
        if (exp_q.size() != 0) begin
            chk("out_data", w_data, exp_q[0][15:0]);
            chk("out_last", w_last, exp_q[0][16]);
            chk("out_src", w_src, exp_q[0][18:17]);
        end
        if (w_err) trunc_pulses++;
        for (int k = 0; k < N; k++)
            assert (!(stuck[k] && !vld[k])) else begin
                miscompares++;
                $error("FAIL req_rule: requester %0d dropped valid while not ready", k);
            end
        if (w_valid && dn_rdy) begin
            lg_src.push_back(int'(w_src)); lg_data.push_back(int'(w_data));
            lg_last.push_back(int'(w_last)); lg_cyc.push_back(cyc);
            if (exp_q.size() != 0) e = exp_q.pop_front();
        end
        trunc_exp = 0;
        if (owner < 0) begin
            g = rr();
            if (g >= 0) begin owner = g; cnt = 0; end
        end else if (vld[owner] && ld) begin
            lb = rq[owner][0][16] || cnt == (sel ? 4 : 64) - 1;
            exp_q.push_back({owner[1:0], lb, rq[owner][0][15:0]});
            trunc_exp = lb && !rq[owner][0][16];
            cnt++;
            if (lb) begin lo[sel] = owner; owner = -1; end
        end
        hs = vld & w_ready;
        stuck = vld & ~w_ready;
    endtask

    task automatic step();
        logic [N-1:0] hs;
        logic [16:0] d;
        drive();
        #2;
        monitor(hs);
        @(negedge clk);
        for (int k = 0; k < N; k++) if (hs[k] && rq[k].size() > 0) d = rq[k].pop_front();
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!all_idle() && n < 2000) begin step(); n++; end
        chk({tag, " drain_timeout"}, n < 2000, 1);
    endtask

    initial begin
        int s, n, t0;
        model_reset();
        repeat (3) @(negedge clk);
        #2 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) step();

        rq[2].push_back({1'b0, 16'hAAAA}); rq[2].push_back({1'b1, 16'hBBBB});
        for (n = 0; n < 10 && !w_valid; n++) step();
        chk("midrst_setup", w_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        for (int k = 0; k < N; k++) rq[k].delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();

        // contention: 0,1,2,3 then requester 0 again
        for (int k = 0; k < N; k++)
            for (int b = 0; b < 3; b++) rq[k].push_back({b == 2, 16'(k * 16 + b)});
        for (int b = 0; b < 3; b++) rq[0].push_back({b == 2, 16'(b)});
        s = lg_src.size();
        drain("contention");
        chk("cont_count", lg_src.size() - s, 15);
        for (int i = 0; i < 12; i++) begin
            chk("cont_src", lg_src[s+i], i / 3);
            chk("cont_data", lg_data[s+i], (i / 3) * 16 + i % 3);
        end
        chk("cont_src5", lg_src[s+12], 0);
        chk("cont_gap", lg_cyc[s+3] - lg_cyc[s+2], 2);

        // fairness between 1 and 3, then 0 joins
        for (int i = 0; i < 6; i++) begin
            rq[1].push_back({1'b1, 16'(16'h100 + i)});
            rq[3].push_back({1'b1, 16'(16'h300 + i)});
        end
        s = lg_src.size();
        for (n = 0; n < 100 && !(owner == 1 && lg_src.size() - s >= 2); n++) step();
        chk("fair_setup", n < 100, 1);
        rq[0].push_back({1'b1, 16'h00F0});
        drain("fair");
        chk("fair_s0", lg_src[s], 1);
        chk("fair_s1", lg_src[s+1], 3);
        chk("fair_s2", lg_src[s+2], 1);
        chk("fair_s3", lg_src[s+3], 3);
        chk("fair_s4", lg_src[s+4], 0);
        chk("fair_s5", lg_src[s+5], 1);

        // backpressure: 2 on, 3 off
        bp_mode = 1;
        for (int i = 0; i < 10; i++) rq[2].push_back({i == 9, 16'(i)});
        s = lg_src.size();
        drain("backpressure");
        bp_mode = 0;
        chk("bp_count", lg_src.size() - s, 10);
        for (int i = 0; i < 10; i++) begin
            chk("bp_data", lg_data[s+i], i);
            chk("bp_last", lg_last[s+i], i == 9);
            chk("bp_src", lg_src[s+i], 2);
        end

        // truncation on the MAX_BEATS=4 instance
        sel = 1'b1;
        for (int i = 0; i < 6; i++) rq[0].push_back({i == 5, 16'(i)});
        s = lg_src.size(); t0 = trunc_pulses;
        drain("truncate");
        chk("trunc_pulses", trunc_pulses - t0, 1);
        chk("trunc_count", lg_src.size() - s, 6);
        for (int i = 0; i < 6; i++) begin
            chk("trunc_data", lg_data[s+i], i);
            chk("trunc_last", lg_last[s+i], i == 3 || i == 5);
        end
        chk("trunc_gap", lg_cyc[s+4] - lg_cyc[s+3], 2);
        sel = 1'b0;

        // valid bubble while requester 1 waits
        for (int i = 0; i < 4; i++) rq[0].push_back({i == 3, 16'(16'h50 + i)});
        s = lg_src.size();
        for (n = 0; n < 20 && !(owner == 0 && cnt >= 2); n++) step();
        chk("bubble_setup", n < 20, 1);
        hold[0] = 1'b1;
        rq[1].push_back({1'b1, 16'h0077});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bubble_rdy1", w_ready[1], 0);
            chk("bubble_busy", w_busy, 1);
        end
        hold[0] = 1'b0;
        drain("bubble");
        chk("bubble_count", lg_src.size() - s, 5);
        for (int i = 0; i < 4; i++) chk("bubble_data", lg_data[s+i], 16'h50 + i);
        chk("bubble_src1", lg_src[s+4], 1);

        // random traffic on both instances
        for (int m = 0; m < 2; m++) begin
            sel = m[0];
            bp_mode = 2;
            for (int c = 0; c < 300; c++) begin
                if ($urandom % 6 == 0) begin
                    int k = int'($urandom % N);
                    int len = 1 + int'($urandom % 6);
                    if (rq[k].size() < 12)
                        for (int b = 0; b < len; b++) rq[k].push_back({b == len - 1, 16'($urandom)});
                end
                hold = 4'($urandom) & 4'($urandom);
                step();
            end
            hold = '0;
            bp_mode = 0;
            drain("random");
        end
        sel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one downstream valid/ready stream, typically a skid buffer input, between NUM_REQ upstream requesters.
- Granularity is the packet: once a requester is granted, it owns the output until it sends a beat with last set.
- Grants rotate round-robin among requesters.
- A beat counter bounds packet length so that a stuck requester cannot hold the resource indefinitely.

Parameters:
- WIDTH, 16: data bits per beat.
- NUM_REQ, 4: number of requesters; legal range 2..16.
- MAX_BEATS, 64: maximum beats per grant before forced release; legal range 2..65535.
- IDX_W, $clog2(NUM_REQ): source-index width (derived; do not override).

Ports:
- i_clock  in  1  system clock; everything is synchronous to its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_in_data  in  NUM_REQ*WIDTH  requester k data in bits [k*WIDTH +: WIDTH].
- i_in_valid  in  NUM_REQ  per-requester valid.
- i_in_last  in  NUM_REQ  per-requester end-of-packet flag; qualified by valid.
- o_in_ready  out  NUM_REQ  per-requester ready; at most one bit high.
- o_out_data  out  WIDTH  registered output data.
- o_out_valid  out  1  registered output valid.
- o_out_last  out  1  registered end-of-packet flag.
- o_out_src  out  IDX_W  index of the requester that produced the current output beat.
- i_out_ready  in  1  downstream ready.
- o_busy  out  1  high while the state is GRANT.
- o_err_truncate  out  1  one-cycle pulse when a packet is force-terminated.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - State is IDLE, beat_cnt=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0, including o_in_ready.
  - Asserting reset mid-packet drops the in-flight beat and the packet; no partial completion occurs after release.
- Handshake:
  - A transfer occurs on any edge where valid and ready are both high. This applies to both ports.
  - Output register load enable: ld = ~o_out_valid | i_out_ready.
  - The output follows AXI-stream rules: while o_out_valid=1 and i_out_ready=0, o_out_data, o_out_last and o_out_src hold.
- IDLE state:
  - All o_in_ready are 0.
  - If any i_in_valid is set, select g = the first index with valid set, searching upward from (last_grant+1) mod NUM_REQ and wrapping.
  - Next cycle: state=GRANT, grant=g, beat_cnt=0.
  - This gives exactly a 1-cycle arbitration bubble per packet.
  - If no valid is set, remain in IDLE.
- GRANT state:
  - o_in_ready[grant] = ld; all other ready bits are 0.
  - On an input transfer, the output register loads the data, out_last = i_in_last[grant] | (beat_cnt==MAX_BEATS-1), out_src=grant, out_valid=1; beat_cnt increments.
  - When ld is high but there is no input transfer, o_out_valid goes to 0.
  - On a transfer whose out_last=1: next state=IDLE, last_grant=grant.
  - If termination was caused by the count and not by i_in_last, o_err_truncate pulses in the same cycle as the last beat is registered.
  - Remaining beats of a truncated packet are arbitrated later as a new packet.
- Latency: the first beat appears on o_out_valid 2 cycles after i_in_valid rises at an idle arbiter.
- Throughput: 1 beat/cycle within a packet while i_out_ready=1.
- Output drain in IDLE: in IDLE, ld still clears o_out_valid when the downstream accepts, so the final beat drains.
- Requester dropping valid: a granted requester that deasserts valid mid-packet keeps the grant. Bubbles are passed downstream as o_out_valid=0.
- Requester side rule: requesters must not drop valid while their ready is 0; this is checked by assertion in the bench.
- beat_cnt: 16 bits; never wraps, because termination occurs at MAX_BEATS-1.

Test Plan:
- Reset, no valids for 100 cycles: o_out_valid=0, o_in_ready=0, o_busy=0 throughout; mid-test reset clears all outputs immediately, without waiting for a clock edge.
- Contention:
  - Stimulus: all 4 requesters present 3-beat packets with data k*16+beat; i_out_ready=1.
  - Required: packets emerge in source order 0,1,2,3,0; o_out_src matches each beat; one idle cycle between packets; exactly 12 beats in the first round.
- Round-robin fairness:
  - Stimulus: requesters 1 and 3 continuously valid with 1-beat packets.
  - Required: sources alternate 1,3,1,3; requester 0 enters valid later and is served right after the next 3.
- Backpressure:
  - Stimulus: requester 2 sends 10 beats counting 0..9; i_out_ready toggles 2 cycles on, 3 cycles off.
  - Required: exactly 10 output beats in order 0..9; no duplicates; data held stable while stalled; last is set only on beat 9.
- Truncation:
  - Stimulus: MAX_BEATS=4; requester 0 sends 6 beats with last only on beat 6.
  - Required: beat 4 has o_out_last=1 and o_err_truncate pulses once; beats 5..6 follow as a separate packet after arbitration; the second packet has no pulse.
- Valid bubble:
  - Stimulus: the granted requester deasserts valid for 5 cycles mid-packet while requester 1 is valid.
  - Required: the grant is retained, o_in_ready[1] stays 0, and the packet completes before requester 1 is served.
